// File: rtl/dot_product_accumulator_pkg.sv
// Shared constants for the dot-product accumulator: default sizing, the
// accumulator width derivation and the control state encoding.
package dot_product_accumulator_pkg;

    localparam int N_DEF     = 4;
    localparam int TERMS_DEF = 4;
    localparam int CW_DEF    = 2;

    // Product is 2N bits; CW extra bits absorb the carry of up to 2^CW terms.
    function automatic int acc_width(input int n, input int cw);
        return 2 * n + cw;
    endfunction

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/dot_product_accumulator_mod_counter.sv
// CW-bit term counter with synchronous clear and a terminal flag at TERMS-1;
// reusable by other sequential multiplier stages.
module dot_product_accumulator_mod_counter #(
    parameter int CW    = 2,
    parameter int TERMS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          term
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == CW'(TERMS - 1));

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums TERMS consecutive unsigned products from the array multiplier and
// holds each completed dot product on a valid/ready output until accepted.
module dot_product_accumulator
    import dot_product_accumulator_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int TERMS = TERMS_DEF,
    parameter int CW    = CW_DEF,
    parameter int ACC_W = acc_width(N, CW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [2*N-1:0]   prod,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    term_cnt
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;

    logic in_xfer;
    logic abort;
    logic last;
    logic cnt_inc;
    logic cnt_clr;

    // Handshake flags depend only on registered state, never on out_ready.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign in_xfer   = in_valid & in_ready;
    assign abort     = clear & in_ready;

    // An aborted transfer still consumes the product but never counts it.
    assign cnt_inc = in_xfer & ~abort & ~last;
    assign cnt_clr = abort | (in_xfer & last);

    dot_product_accumulator_mod_counter #(
        .CW    (CW),
        .TERMS (TERMS)
    ) u_term_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .cnt  (term_cnt),
        .term (last)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        case (state_q)
            ACCUM: begin
                if (abort) begin
                    acc_d = '0;
                end else if (in_xfer) begin
                    if (last) begin
                        sum_d   = acc_q + ACC_W'(prod);
                        acc_d   = '0;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_q + ACC_W'(prod);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
        end
    end

    assign out_sum = sum_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed plus randomized checks of dot_product_accumulator against a
// queue-based model of accepted products per group.
module tb_dot_product_accumulator;

    localparam int N     = 4;
    localparam int TERMS = 4;
    localparam int CW    = 2;
    localparam int ACC_W = 2 * N + CW;

    logic             clk;
    logic             rst;
    logic             clear;
    logic [2*N-1:0]   prod;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    term_cnt;

    int total = 0;
    int bad   = 0;

    // model: products accepted in the open group, held result and hold flag
    int unsigned grp[$];
    int unsigned m_sum  = 0;
    bit          m_hold = 0;

    dot_product_accumulator #(
        .N     (N),
        .TERMS (TERMS),
        .CW    (CW),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .prod      (prod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .term_cnt  (term_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_model();
        check("in_ready",  {31'd0, in_ready},  {31'd0, ~m_hold});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
        check("out_sum",   32'(out_sum),       m_sum);
        check("term_cnt",  32'(term_cnt),      grp.size());
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic cyc(input bit v, input logic [7:0] p, input bit r, input bit c);
        int unsigned s;
        in_valid  = v;
        prod      = v ? p : 'x;
        out_ready = r;
        clear     = c;
        if (m_hold) begin
            if (r) m_hold = 0;
        end else if (c) begin
            grp.delete();
        end else if (v) begin
            grp.push_back(int'(p));
            if (grp.size() == TERMS) begin
                s = 0;
                foreach (grp[i]) s += grp[i];
                m_sum  = s;
                m_hold = 1;
                grp.delete();
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic model_reset();
        grp.delete();
        m_sum  = 0;
        m_hold = 0;
    endtask

    initial begin
        logic [7:0] vals[4];
        int         idx;
        int         guard;
        bit         v;

        rst       = 1'b1;
        clear     = 1'b0;
        prod      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum",   32'(out_sum),       32'd0);
        check("rst_term_cnt",  32'(term_cnt),      32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        rst = 1'b0;

        // 1+2+3+4 back to back
        cyc(1, 8'd1, 1, 0);
        cyc(1, 8'd2, 1, 0);
        cyc(1, 8'd3, 1, 0);
        cyc(1, 8'd4, 1, 0);
        check("sum_1234", 32'(out_sum), 32'd10);
        cyc(0, 8'd0, 1, 0);
        check("valid_one_cycle", {31'd0, out_valid}, 32'd0);

        // full-scale products, then hold under back-pressure with prod=7 offered
        repeat (4) cyc(1, 8'd225, 0, 0);
        check("sum_900", 32'(out_sum), 32'd900);
        repeat (5) cyc(1, 8'd7, 0, 0);
        check("hold_900", 32'(out_sum), 32'd900);
        check("hold_cnt", 32'(term_cnt), 32'd0);
        cyc(1, 8'd7, 1, 0);
        check("release_cnt", 32'(term_cnt), 32'd0);
        cyc(0, 8'd0, 1, 1);

        // clear mid-group with a product offered
        cyc(1, 8'd5, 1, 0);
        cyc(1, 8'd6, 1, 0);
        cyc(1, 8'd9, 1, 1);
        check("clear_cnt", 32'(term_cnt), 32'd0);
        repeat (4) cyc(1, 8'd1, 1, 0);
        check("sum_after_clear", 32'(out_sum), 32'd4);
        cyc(0, 8'd0, 1, 0);

        // clear while holding is ignored
        repeat (4) cyc(1, 8'd3, 0, 0);
        cyc(0, 8'd0, 0, 1);
        check("clear_in_hold", 32'(out_sum), 32'd12);
        cyc(0, 8'd0, 1, 0);

        // asynchronous reset after three terms
        cyc(1, 8'd50, 1, 0);
        cyc(1, 8'd60, 1, 0);
        cyc(1, 8'd70, 1, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_term_cnt", 32'(term_cnt), 32'd0);
        check("arst_out_sum",  32'(out_sum),  32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("arst_cnt_seq", 32'(term_cnt), 32'(i));
            cyc(1, 8'd2, 1, 0);
        end
        check("sum_2222", 32'(out_sum), 32'd8);
        cyc(0, 8'd0, 1, 0);

        // random gaps over 10,20,30,40
        vals[0] = 8'd10;
        vals[1] = 8'd20;
        vals[2] = 8'd30;
        vals[3] = 8'd40;
        for (int r = 0; r < 4; r++) begin
            idx   = 0;
            guard = 0;
            while (idx < 4) begin
                v = ($urandom % 2 == 1) || (guard > 40);
                cyc(v, vals[idx], 1, 0);
                if (v) idx++;
                guard++;
            end
            check("sum_gaps", 32'(out_sum), 32'd100);
            cyc(0, 8'd0, 1, 0);
        end

        // fully random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom % 4) != 0, 8'($urandom_range(0, 225)),
                ($urandom % 3) != 0, ($urandom % 16) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
